// File: rtl/i2c_bus_interface.sv
// I2C target bit/byte layer: synchronises SDA/SCL, detects START/STOP, deserialises
// received bytes and shifts a requested byte out on open-drain SDA under external SCL.
module i2c_bus_interface #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        SDA,
  input  logic       SCL,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_req,
  output logic       tx_ready
);

  typedef enum logic [1:0] {IDLE, ACTIVE, TX} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_prev, sda_prev;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]             bit_cnt, bit_cnt_next;
  logic [6:0]             rx_shift, rx_shift_next;
  logic [7:0]             rx_data_next;
  logic                   rx_valid_next;
  logic [6:0]             tx_shift, tx_shift_next;
  logic                   sda_low, sda_low_next;

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign start_det = scl_s & sda_prev & ~sda_s;
  assign stop_det  = scl_s & ~sda_prev & sda_s;

  assign tx_ready = (state == ACTIVE) && (bit_cnt == 4'd0) && !scl_s;

  // Open-drain: only ever pull low; reset clears sda_low asynchronously
  assign SDA = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      rx_shift <= 7'd0;
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      tx_shift <= 7'd0;
      sda_low  <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA};
      scl_prev <= scl_s;
      sda_prev <= sda_s;
      state    <= state_next;
      bit_cnt  <= bit_cnt_next;
      rx_shift <= rx_shift_next;
      rx_data  <= rx_data_next;
      rx_valid <= rx_valid_next;
      tx_shift <= tx_shift_next;
      sda_low  <= sda_low_next;
    end
  end

  // START/STOP override everything, including a byte completing in the same cycle
  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    rx_shift_next = rx_shift;
    rx_data_next  = rx_data;
    rx_valid_next = 1'b0;
    tx_shift_next = tx_shift;
    sda_low_next  = sda_low;
    if (start_det || stop_det) begin
      state_next    = start_det ? ACTIVE : IDLE;
      bit_cnt_next  = 4'd0;
      rx_shift_next = 7'd0;
      sda_low_next  = 1'b0;
    end else begin
      case (state)
        ACTIVE: begin
          if (tx_req && tx_ready) begin
            state_next    = TX;
            tx_shift_next = tx_data[6:0];
            sda_low_next  = ~tx_data[7];
          end else if (scl_rise) begin
            if (bit_cnt == 4'd7) begin
              rx_data_next  = {rx_shift, sda_s};
              rx_valid_next = 1'b1;
              bit_cnt_next  = 4'd0;
            end else begin
              rx_shift_next = {rx_shift[5:0], sda_s};
              bit_cnt_next  = bit_cnt + 4'd1;
            end
          end
        end
        TX: begin
          // Entry requires SCL low, so every fall seen here follows a counted rise
          if (scl_rise) begin
            bit_cnt_next = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_next   = ACTIVE;
              bit_cnt_next = 4'd0;
              sda_low_next = 1'b0;
            end else begin
              sda_low_next  = ~tx_shift[6];
              tx_shift_next = {tx_shift[5:0], 1'b1};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_interface.sv
// Self-checking bench for i2c_bus_interface: directed and randomized I2C traffic
// against a bus-level model of expected received bytes and transmit behaviour.
module tb_i2c_bus_interface;

  typedef enum int {M_IDLE, M_ACTIVE, M_TX} mstate_t;

  logic       clk;
  logic       reset;
  logic       SCL;
  logic       tb_sda_low;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_ready;
  wire        sda_bus;

  pullup (sda_bus);
  assign sda_bus = tb_sda_low ? 1'b0 : 1'bz;

  i2c_bus_interface #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .SDA(sda_bus), .SCL(SCL),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_req(tx_req), .tx_ready(tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         half = 50;
  int         pulse_cnt = 0;
  int         scl_lo_cnt = 0;
  int         scl_hi_cnt = 0;
  mstate_t    model_state = M_IDLE;
  int         model_cnt = 0;
  logic [7:0] model_acc = 8'd0;
  logic [7:0] model_rx = 8'd0;
  logic [7:0] exp_q[$];

  task automatic check_output(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  // Bus-level model: bytes are framed purely from pin events the bench creates
  task automatic model_rise(input logic b);
    if (model_state == M_ACTIVE) begin
      model_acc = model_acc * 2 + 8'(b);
      model_cnt++;
      if (model_cnt == 8) begin
        exp_q.push_back(model_acc);
        model_cnt = 0;
      end
    end
  endtask

  task automatic model_frame(input mstate_t s);
    model_state = s;
    model_cnt   = 0;
    model_acc   = 8'd0;
  endtask

  task automatic model_reset();
    model_frame(M_IDLE);
    model_rx = 8'd0;
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    #1;
    if (SCL) begin scl_hi_cnt++; scl_lo_cnt = 0; end
    else     begin scl_lo_cnt++; scl_hi_cnt = 0; end
    if (!reset) begin
      check_output("rx_valid in reset", 8'(rx_valid), 8'd0);
      check_output("rx_data in reset", rx_data, 8'd0);
      check_output("tx_ready in reset", 8'(tx_ready), 8'd0);
    end else begin
      if (rx_valid) begin
        pulse_cnt++;
        if (exp_q.size() == 0) begin
          check_output("unexpected rx_valid", 8'(rx_valid), 8'd0);
        end else begin
          model_rx = exp_q.pop_front();
          check_output("rx_data on pulse", rx_data, model_rx);
        end
      end else begin
        check_output("rx_data hold", rx_data, model_rx);
      end
      if (scl_lo_cnt >= 4)
        check_output("tx_ready", 8'(tx_ready), 8'(model_state == M_ACTIVE && model_cnt == 0));
      else if (scl_hi_cnt >= 3)
        check_output("tx_ready scl high", 8'(tx_ready), 8'd0);
    end
  end

  task automatic send_bit(input logic b);
    tb_sda_low = !b;
    #(half);
    SCL = 1'b1;
    model_rise(sda_bus);
    #(half);
    SCL = 1'b0;
    #(half);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic i2c_start();
    if (SCL == 1'b0) begin
      tb_sda_low = 1'b0;
      #(half);
      SCL = 1'b1;
      model_rise(sda_bus);
      #(half);
    end
    tb_sda_low = 1'b1;
    model_frame(M_ACTIVE);
    #(half);
    SCL = 1'b0;
    #(half);
  endtask

  task automatic i2c_stop();
    tb_sda_low = 1'b1;
    #(half);
    SCL = 1'b1;
    model_rise(sda_bus);
    #(half);
    tb_sda_low = 1'b0;
    model_frame(M_IDLE);
    #(half);
  endtask

  task automatic apply_stimulus_tx(input logic [7:0] b, input int abort_at, output logic [7:0] seen);
    seen = 8'd0;
    check_output("tx_ready before req", 8'(tx_ready), 8'(model_state == M_ACTIVE && model_cnt == 0));
    tb_sda_low = 1'b0;
    @(negedge clk);
    tx_data = b;
    tx_req  = 1'b1;
    @(negedge clk);
    model_state = M_TX;
    @(negedge clk);
    tx_req  = 1'b0;
    tx_data = 8'($urandom);
    #(half);
    for (int i = 0; i < 8; i++) begin
      SCL = 1'b1;
      seen[7-i] = sda_bus;
      check_output("tx bit", 8'(sda_bus), 8'(b[7-i]));
      if (i == abort_at) begin
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check_output("sda async release", 8'(sda_bus), 8'd1);
        check_output("tx_ready after reset", 8'(tx_ready), 8'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      #(half);
      SCL = 1'b0;
      if (i == 7) model_frame(M_ACTIVE);
      #(half);
    end
    check_output("sda released after tx", 8'(sda_bus), 8'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_output("missing rx_valid", 8'(exp_q.size()), 8'd0);
    exp_q.delete();
  endtask

  int         p0;
  int         nexp;
  int         nb;
  int         npart;
  logic [7:0] seen;

  initial begin
    reset      = 1'b1;
    SCL        = 1'b1;
    tb_sda_low = 1'b0;
    tx_data    = 8'd0;
    tx_req     = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset rx_valid", 8'(rx_valid), 8'd0);
    check_output("reset rx_data", rx_data, 8'h00);
    check_output("reset tx_ready", 8'(tx_ready), 8'd0);
    check_output("reset SDA", 8'(sda_bus), 8'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    p0 = pulse_cnt;
    i2c_start();
    send_byte(8'h55);
    i2c_stop();
    drain();
    check_output("pulses 55", 8'(pulse_cnt - p0), 8'd1);
    check_output("rx_data 55", rx_data, 8'h55);

    p0 = pulse_cnt;
    i2c_start();
    apply_stimulus_tx(8'hAA, -1, seen);
    check_output("tx sampled AA", seen, 8'hAA);
    check_output("tx_ready after tx", 8'(tx_ready), 8'd1);
    i2c_stop();
    drain();
    check_output("pulses tx", 8'(pulse_cnt - p0), 8'd0);

    p0 = pulse_cnt;
    i2c_start();
    for (int i = 0; i < 4; i++) send_bit(1'(i));
    i2c_stop();
    drain();
    check_output("pulses partial", 8'(pulse_cnt - p0), 8'd0);
    i2c_start();
    send_byte(8'hC3);
    i2c_stop();
    drain();
    check_output("pulses C3", 8'(pulse_cnt - p0), 8'd1);
    check_output("rx_data C3", rx_data, 8'hC3);

    p0 = pulse_cnt;
    i2c_start();
    send_byte(8'h12);
    send_byte(8'h34);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    i2c_start();
    i2c_stop();
    drain();
    check_output("pulses 12 34", 8'(pulse_cnt - p0), 8'd2);
    check_output("rx_data 34", rx_data, 8'h34);

    i2c_start();
    apply_stimulus_tx(8'h00, 2, seen);
    #(half);
    SCL = 1'b0;
    repeat (6) @(negedge clk);
    check_output("tx_ready idle after reset", 8'(tx_ready), 8'd0);
    SCL = 1'b1;
    #(half);
    i2c_start();
    check_output("tx_ready after start", 8'(tx_ready), 8'd1);
    i2c_stop();
    drain();

    // Randomized frames: bytes, optional transmits at byte boundaries, ragged ends
    for (int it = 0; it < 20; it++) begin
      half = int'($urandom_range(10, 4)) * 10;
      p0   = pulse_cnt;
      nexp = 0;
      i2c_start();
      nb = int'($urandom_range(3, 1));
      for (int j = 0; j < nb; j++) begin
        send_byte(8'($urandom));
        nexp++;
        if ($urandom_range(2, 0) == 0) apply_stimulus_tx(8'($urandom), -1, seen);
      end
      npart = int'($urandom_range(6, 0));
      for (int k = 0; k < npart; k++) send_bit(1'($urandom));
      if ($urandom_range(1, 0) == 0) i2c_start();
      i2c_stop();
      drain();
      check_output("random pulses", 8'(pulse_cnt - p0), 8'(nexp));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
